// File: rtl/exec_stim_gen.sv
// EXEC-side stimulus generator for IFD unit-level validation: drives stall and
// PC_value in alternating hold phases with fixed or LFSR-derived phase lengths.
module exec_stim_gen #(
    parameter int                    ADDR_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0] START_PC   = 12'o200,
    parameter int                    NUM_TXNS   = 50,
    parameter int                    DELAY_BITS = 4,
    parameter logic [15:0]           LFSR_SEED  = 16'hACE1,
    parameter int                    CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mode_rand,
    input  logic [DELAY_BITS-1:0] fixed_delay,
    input  logic                  jump_valid,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    output logic                  stall,
    output logic [ADDR_WIDTH-1:0] PC_value,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      txn_count
);

    localparam int TW = DELAY_BITS + 1;
    localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [DELAY_BITS-1:0] DELAY_ONES = {DELAY_BITS{1'b1}};
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE,
        PHASE_A,
        PHASE_B,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic [DELAY_BITS-1:0]   delay_q, delay_d;
    logic [15:0]             lfsr_q, lfsr_d;
    logic                    stall_q, stall_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]        txn_q, txn_d;
    logic                    pend_q, pend_d;
    logic [ADDR_WIDTH-1:0]   pend_addr_q, pend_addr_d;
    logic                    busy_q, done_q;

    logic [15:0]             lfsr_next;
    logic [DELAY_BITS-1:0]   rand_r;
    logic [DELAY_BITS-1:0]   rand_delay;
    logic [DELAY_BITS-1:0]   draw_delay;
    logic [TW-1:0]           draw_load;
    logic [TW-1:0]           hold_load;
    logic                    timer_end;

    // Galois step for x^16+x^14+x^13+x^11+1; all-ones folds to 0 so the draw is r mod (2^DELAY_BITS-1).
    always_comb begin
        lfsr_next  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        rand_r     = lfsr_q[DELAY_BITS-1:0];
        rand_delay = (rand_r == DELAY_ONES) ? '0 : rand_r;
        draw_delay = mode_rand ? rand_delay : fixed_delay;
        draw_load  = {1'b0, draw_delay} + TW'(1);
        hold_load  = {1'b0, delay_q} + TW'(1);
        timer_end  = (timer_q == '0);
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        delay_d     = delay_q;
        lfsr_d      = lfsr_q;
        stall_d     = stall_q;
        pc_d        = pc_q;
        txn_d       = txn_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = PHASE_A;
                    stall_d = ~stall_q;
                    txn_d   = '0;
                    pc_d    = START_PC;
                    pend_d  = 1'b0;
                    delay_d = draw_delay;
                    timer_d = draw_load;
                    lfsr_d  = lfsr_next;
                end
            end
            PHASE_A: begin
                if (timer_end) begin
                    // A direct request on the update cycle supersedes any older pending target.
                    if (jump_valid) begin
                        pc_d = jump_addr;
                    end else if (pend_q) begin
                        pc_d = pend_addr_q;
                    end else begin
                        pc_d = pc_q + ADDR_WIDTH'(1);
                    end
                    pend_d  = 1'b0;
                    txn_d   = txn_q + CNT_W'(1);
                    state_d = PHASE_B;
                    timer_d = hold_load;
                end else begin
                    timer_d = timer_q - TW'(1);
                    if (jump_valid) begin
                        pend_d      = 1'b1;
                        pend_addr_d = jump_addr;
                    end
                end
            end
            PHASE_B: begin
                if (jump_valid) begin
                    pend_d      = 1'b1;
                    pend_addr_d = jump_addr;
                end
                if (timer_end) begin
                    if (txn_q == CNT_W'(NUM_TXNS)) begin
                        state_d = DONE;
                    end else begin
                        state_d = PHASE_A;
                        stall_d = ~stall_q;
                        delay_d = draw_delay;
                        timer_d = draw_load;
                        lfsr_d  = lfsr_next;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            delay_q     <= '0;
            lfsr_q      <= SEED_EFF;
            stall_q     <= 1'b1;
            pc_q        <= START_PC;
            txn_q       <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            delay_q     <= delay_d;
            lfsr_q      <= lfsr_d;
            stall_q     <= stall_d;
            pc_q        <= pc_d;
            txn_q       <= txn_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            busy_q      <= (state_d == PHASE_A) || (state_d == PHASE_B);
            done_q      <= (state_d == DONE);
        end
    end

    assign stall     = stall_q;
    assign PC_value  = pc_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign txn_count = txn_q;

endmodule

// File: tb/tb_exec_stim_gen.sv
// Self-checking bench for exec_stim_gen: directed scenarios plus a randomized
// soak, all compared cycle by cycle against a phase-length reference model.
module tb_exec_stim_gen;

    localparam int ADDR_WIDTH = 12;
    localparam int DELAY_BITS = 4;
    localparam int NUM_TXNS   = 50;
    localparam int CNT_W      = 8;
    localparam int START_PC   = 'o200;
    localparam int SEED       = 'hACE1;
    localparam int ADDR_MOD   = 1 << ADDR_WIDTH;
    localparam int DELAY_MOD  = 1 << DELAY_BITS;

    logic                  clk;
    logic                  reset;
    logic                  start;
    logic                  mode_rand;
    logic [DELAY_BITS-1:0] fixed_delay;
    logic                  jump_valid;
    logic [ADDR_WIDTH-1:0] jump_addr;
    logic                  stall;
    logic [ADDR_WIDTH-1:0] PC_value;
    logic                  busy;
    logic                  done;
    logic [CNT_W-1:0]      txn_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: a run is a sequence of transactions, each an A hold then a B hold
    // of delay+2 cycles; mLeft counts cycles still to go in the current hold.
    bit mStall = 1'b1;
    int mPc = START_PC;
    int mTxn = 0;
    bit mBusy = 1'b0;
    bit mDone = 1'b0;
    bit mInB = 1'b0;
    int mLeft = 0;
    int mDelay = 0;
    bit mPend = 1'b0;
    int mPendAddr = 0;
    int mLfsr = SEED;

    exec_stim_gen #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .START_PC  (12'o200),
        .NUM_TXNS  (NUM_TXNS),
        .DELAY_BITS(DELAY_BITS),
        .LFSR_SEED (16'hACE1),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode_rand  (mode_rand),
        .fixed_delay(fixed_delay),
        .jump_valid (jump_valid),
        .jump_addr  (jump_addr),
        .stall      (stall),
        .PC_value   (PC_value),
        .busy       (busy),
        .done       (done),
        .txn_count  (txn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic mr,
                                 input logic [DELAY_BITS-1:0] fd, input logic jv,
                                 input logic [ADDR_WIDTH-1:0] ja);
        reset       = r;
        start       = s;
        mode_rand   = mr;
        fixed_delay = fd;
        jump_valid  = jv;
        jump_addr   = ja;
    endtask

    function automatic int lfsrStep(input int x);
        return (x >> 1) ^ (((x & 1) != 0) ? 'hB400 : 0);
    endfunction

    function automatic int drawDelay();
        int d;
        if (mode_rand) d = (mLfsr % DELAY_MOD) % (DELAY_MOD - 1);
        else           d = int'(fixed_delay);
        mLfsr = lfsrStep(mLfsr);
        return d;
    endfunction

    task automatic latchJump();
        if (jump_valid) begin
            mPend     = 1'b1;
            mPendAddr = int'(jump_addr);
        end
    endtask

    task automatic modelEdge();
        if (reset) begin
            mStall = 1'b1; mPc = START_PC; mTxn = 0; mBusy = 1'b0; mDone = 1'b0;
            mInB = 1'b0; mLeft = 0; mPend = 1'b0; mLfsr = SEED;
        end else if (!mBusy) begin
            if (start) begin
                mBusy = 1'b1; mDone = 1'b0; mInB = 1'b0; mStall = !mStall;
                mTxn = 0; mPc = START_PC; mPend = 1'b0;
                mDelay = drawDelay();
                mLeft = mDelay + 2;
            end
        end else if (!mInB) begin
            if (mLeft == 1) begin
                if (jump_valid) mPc = int'(jump_addr);
                else if (mPend) mPc = mPendAddr;
                else            mPc = (mPc + 1) % ADDR_MOD;
                mPend = 1'b0;
                mTxn++;
                mInB = 1'b1;
                mLeft = mDelay + 2;
            end else begin
                mLeft--;
                latchJump();
            end
        end else begin
            latchJump();
            if (mLeft == 1) begin
                if (mTxn == NUM_TXNS) begin
                    mBusy = 1'b0;
                    mDone = 1'b1;
                end else begin
                    mInB = 1'b0;
                    mStall = !mStall;
                    mDelay = drawDelay();
                    mLeft = mDelay + 2;
                end
            end else begin
                mLeft--;
            end
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        modelEdge();
        #1;
        cyc++;
        checkOutput("stall", 32'(stall), 32'(mStall));
        checkOutput("pc", 32'(PC_value), 32'(mPc));
        checkOutput("busy", 32'(busy), 32'(mBusy));
        checkOutput("done", 32'(done), 32'(mDone));
        checkOutput("txn", 32'(txn_count), 32'(mTxn));
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "Stall"}, 32'(stall), 1);
        checkOutput({tag, "Pc"}, 32'(PC_value), START_PC);
        checkOutput({tag, "Busy"}, 32'(busy), 0);
        checkOutput({tag, "Done"}, 32'(done), 0);
        checkOutput({tag, "Txn"}, 32'(txn_count), 0);
    endtask

    initial begin
        bit doneSeen;
        bit prevStall;
        logic [ADDR_WIDTH-1:0] prevPc;
        int tStall, tPc, lenA, lenB;

        // Reset held two cycles, then held with start high: must stay idle.
        applyStimulus(1, 1, 0, 3, 0, 0);
        stepCycle();
        stepCycle();
        checkReset("t1");
        stepCycle();
        checkOutput("t1BusyHeld", 32'(busy), 0);

        // Fixed delay 3: phases of 5 cycles, start sampled in cycle 0.
        applyStimulus(0, 1, 0, 3, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            stepCycle();
            if (k == 1)  checkOutput("t2Stall1", 32'(stall), 0);
            if (k == 5)  checkOutput("t2Pc5", 32'(PC_value), 'o200);
            if (k == 6)  checkOutput("t2Pc6", 32'(PC_value), 'o201);
            if (k == 10) checkOutput("t2Stall10", 32'(stall), 0);
            if (k == 11) checkOutput("t2Stall11", 32'(stall), 1);
            if (k == 16) checkOutput("t2Pc16", 32'(PC_value), 'o202);
            if (k == 16) checkOutput("t2Txn16", 32'(txn_count), 2);
            applyStimulus(0, 0, 0, 3, 0, 0);
        end

        // Fixed delay 0: wrap past 7777, direct and pending jumps, pending overwrite.
        applyStimulus(1, 0, 0, 0, 0, 0);
        stepCycle();
        applyStimulus(0, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 23; k++) begin
            stepCycle();
            if (k == 1)  checkOutput("t3Stall1", 32'(stall), 0);
            if (k == 2)  checkOutput("t3Pc2", 32'(PC_value), 'o200);
            if (k == 3)  checkOutput("t3PendJump", 32'(PC_value), 'o7777);
            if (k == 5)  checkOutput("t3Stall5", 32'(stall), 1);
            if (k == 7)  checkOutput("t3Wrap", 32'(PC_value), 0);
            if (k == 7)  checkOutput("t3Txn7", 32'(txn_count), 2);
            if (k == 11) checkOutput("t4Direct", 32'(PC_value), 'o400);
            if (k == 15) checkOutput("t4Incr", 32'(PC_value), 'o401);
            if (k == 19) checkOutput("t4Overwrite", 32'(PC_value), 'o555);
            if (k == 23) checkOutput("t4Incr2", 32'(PC_value), 'o556);
            case (k)
                1:       applyStimulus(0, 0, 0, 0, 1, 12'o7777);
                10:      applyStimulus(0, 0, 0, 0, 1, 12'o400);
                16:      applyStimulus(0, 0, 0, 0, 1, 12'o111);
                17:      applyStimulus(0, 0, 0, 0, 1, 12'o555);
                default: applyStimulus(0, 0, 0, 0, 0, 12'($urandom_range(0, ADDR_MOD - 1)));
            endcase
        end

        // LFSR delays: two full runs from reset, measuring every hold length.
        for (int run = 0; run < 2; run++) begin
            applyStimulus(1, 0, 1, 0, 0, 0);
            stepCycle();
            applyStimulus(0, 1, 1, 0, 0, 0);
            doneSeen = 1'b0;
            prevStall = stall;
            prevPc = PC_value;
            tStall = cyc + 1;
            tPc = 0;
            lenA = 0;
            for (int i = 0; i < NUM_TXNS * 34 + 20 && !doneSeen; i++) begin
                stepCycle();
                applyStimulus(0, 0, 1, 0, 0, 0);
                if (stall != prevStall) begin
                    if (i > 0) begin
                        lenB = cyc - tPc;
                        checkOutput("t5LenB", 32'(lenB), 32'(lenA));
                    end
                    tStall = cyc;
                end
                if (PC_value != prevPc) begin
                    lenA = cyc - tStall;
                    checkOutput("t5LenARange", 32'(lenA >= 2 && lenA <= 16), 1);
                    tPc = cyc;
                end
                if (done) begin
                    doneSeen = 1'b1;
                    lenB = cyc - tPc;
                    checkOutput("t5LenBLast", 32'(lenB), 32'(lenA));
                end
                prevStall = stall;
                prevPc = PC_value;
            end
            checkOutput("t5DoneSeen", 32'(doneSeen), 1);
            checkOutput("t5FinalPc", 32'(PC_value), 'o262);
            checkOutput("t5FinalTxn", 32'(txn_count), NUM_TXNS);
        end

        // Reset mid-PHASE_B, start while busy, restart from DONE.
        applyStimulus(1, 0, 0, 3, 0, 0);
        stepCycle();
        applyStimulus(0, 1, 0, 3, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            stepCycle();
            applyStimulus(0, 0, 0, 3, 0, 0);
        end
        checkOutput("t6InB", 32'(txn_count), 1);
        applyStimulus(1, 0, 0, 3, 0, 0);
        stepCycle();
        checkReset("t6Rst");
        applyStimulus(0, 1, 0, 0, 0, 0);
        stepCycle();
        applyStimulus(0, 1, 0, 0, 0, 0);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        stepCycle();
        checkOutput("t6BusyStartPc", 32'(PC_value), 'o201);
        checkOutput("t6BusyStartTxn", 32'(txn_count), 1);
        doneSeen = 1'b0;
        for (int i = 0; i < 300 && !doneSeen; i++) begin
            stepCycle();
            if (done) doneSeen = 1'b1;
        end
        checkOutput("t6DoneSeen", 32'(doneSeen), 1);
        checkOutput("t6DoneStall", 32'(stall), 1);
        checkOutput("t6DonePc", 32'(PC_value), 'o262);
        applyStimulus(0, 1, 0, 0, 0, 0);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t6RestartPc", 32'(PC_value), 'o200);
        checkOutput("t6RestartStall", 32'(stall), 0);
        checkOutput("t6RestartBusy", 32'(busy), 1);

        // Random soak: every input varies, the model follows each cycle.
        for (int i = 0; i < 4000; i++) begin
            applyStimulus(($urandom_range(0, 299) == 0),
                          ($urandom_range(0, 19) == 0),
                          1'($urandom_range(0, 1)),
                          DELAY_BITS'($urandom_range(0, DELAY_MOD - 1)),
                          ($urandom_range(0, 5) == 0),
                          ADDR_WIDTH'($urandom_range(0, ADDR_MOD - 1)));
            stepCycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
